camera_qsys_onchip_ram_dp: RTL and testbench

Parametrised true-dual-port Avalon-MM on-chip RAM for the camera Qsys system: successor of the single-port on-chip memory. It adds two independent slaves (s1 for the Nios data master, s2 for a DMA or VIP frame-reader), selectable read latency with `readdatavalid`, and an optional hardware zero-clear after reset. It also defines behaviour for port collisions and out-of-range accesses.

---
 rtl/onchip_ram_pkg.sv | 16 +
 rtl/onchip_ram_tdp_core.sv | 41 ++++
 rtl/camera_qsys_onchip_ram_dp.sv | 175 +++++++++++++++++
 tb/tb_camera_qsys_onchip_ram_dp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared types and helpers for the dual-port on-chip RAM
package onchip_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    function automatic int f_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_ram_tdp_core.sv
// rtl/onchip_ram_tdp_core.sv - inferred true-dual-port RAM with byte-enable writes and old-data reads
module onchip_ram_tdp_core
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000,
    parameter int IW     = 15
) (
    input  logic                clk,
    input  logic                en,
    input  logic [IW-1:0]       a_addr,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic                a_we,
    input  logic                a_re,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic [IW-1:0]       b_addr,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic                b_we,
    input  logic                b_re,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata
);

    localparam int LANES = f_lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Reads sample the array before this edge's writes land, giving old data on a collision.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int l = 0; l < LANES; l++) begin
                if (a_we && a_be[l]) mem[a_addr][l*8 +: 8] <= a_wdata[l*8 +: 8];
                if (b_we && b_be[l]) mem[b_addr][l*8 +: 8] <= b_wdata[l*8 +: 8];
            end
            if (a_re) a_rdata <= mem[a_addr];
            if (b_re) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/camera_qsys_onchip_ram_dp.sv
// rtl/camera_qsys_onchip_ram_dp.sv - dual-slave Avalon-MM on-chip RAM with zero-clear and read latency pipes
module camera_qsys_onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 32000,
    parameter int ADDR_W         = 15,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = "camera_qsys_onchip_memory2.hex"
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest
);

    localparam int              LANES   = f_lanes(DATA_W);
    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
        $error("ADDR_W too narrow for DEPTH");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (CLEAR_ON_RESET == 0 && $bits(INIT_FILE) < 8) begin : g_bad_init
        $error("INIT_FILE must name a preload image when CLEAR_ON_RESET is 0");
    end

    state_t          state;
    logic [IW-1:0]   clear_addr;
    logic            in_clear;
    logic            busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clear_addr <= '0;
        end else if (clken && state == CLEAR) begin
            if (clear_addr == IW'(DEPTH - 1)) state <= RUN;
            else                              clear_addr <= clear_addr + 1'b1;
        end
    end

    assign in_clear       = (state == CLEAR);
    assign busy           = ~reset_n | in_clear | ~clken;
    assign s1_waitrequest = busy;
    assign s2_waitrequest = busy;

    logic                s1_acc, s2_acc, s1_ok, s2_ok, s1_wr_ok, s2_wr_ok, clash;
    logic [IW-1:0]       s1_idx, s2_idx;
    logic [LANES-1:0]    s2_be_eff;
    logic [1:0]          rd_acc, rd_ok;

    assign s1_acc   = s1_chipselect & (s1_read | s1_write) & ~busy;
    assign s2_acc   = s2_chipselect & (s2_read | s2_write) & ~busy;
    assign s1_ok    = ({1'b0, s1_address} < DEPTH_X);
    assign s2_ok    = ({1'b0, s2_address} < DEPTH_X);
    assign s1_idx   = s1_ok ? s1_address[IW-1:0] : '0;
    assign s2_idx   = s2_ok ? s2_address[IW-1:0] : '0;
    assign s1_wr_ok = s1_acc & s1_write & s1_ok;
    assign s2_wr_ok = s2_acc & s2_write & s2_ok;
    assign rd_acc   = {s2_acc & s2_read & ~s2_write, s1_acc & s1_read & ~s1_write};
    assign rd_ok    = {s2_ok, s1_ok};

    // s1 owns every lane both ports enable on the same word; s2 keeps only the rest.
    assign clash     = s1_wr_ok & s2_wr_ok & (s1_address == s2_address);
    assign s2_be_eff = clash ? (s2_byteenable & ~s1_byteenable) : s2_byteenable;

    logic [IW-1:0]     a_addr;
    logic [LANES-1:0]  a_be;
    logic              a_we, a_re;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] q [2];

    assign a_addr  = in_clear ? clear_addr : s1_idx;
    assign a_be    = in_clear ? {LANES{1'b1}} : s1_byteenable;
    assign a_we    = in_clear | s1_wr_ok;
    assign a_re    = ~in_clear & rd_acc[0];
    assign a_wdata = in_clear ? '0 : s1_writedata;

    onchip_ram_tdp_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_core (
        .clk     (clk),
        .en      (clken),
        .a_addr  (a_addr),
        .a_be    (a_be),
        .a_we    (a_we),
        .a_re    (a_re),
        .a_wdata (a_wdata),
        .a_rdata (q[0]),
        .b_addr  (s2_idx),
        .b_be    (s2_be_eff),
        .b_we    (s2_wr_ok),
        .b_re    (rd_acc[1]),
        .b_wdata (s2_writedata),
        .b_rdata (q[1])
    );

    // Stage 1 tracks the RAM output register; ok1 masks data from out-of-range reads.
    logic [1:0]        v1, ok1, vout;
    logic [DATA_W-1:0] d1   [2];
    logic [DATA_W-1:0] dout [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1  <= '0;
            ok1 <= '0;
        end else if (clken) begin
            v1 <= rd_acc;
            for (int p = 0; p < 2; p++) begin
                if (rd_acc[p]) ok1[p] <= rd_ok[p];
            end
        end
    end

    assign d1[0] = ok1[0] ? q[0] : '0;
    assign d1[1] = ok1[1] ? q[1] : '0;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0]        v2;
        logic [DATA_W-1:0] d2 [2];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2 <= '0;
                for (int p = 0; p < 2; p++) d2[p] <= '0;
            end else if (clken) begin
                v2 <= v1;
                for (int p = 0; p < 2; p++) begin
                    if (v1[p]) d2[p] <= d1[p];
                end
            end
        end

        assign vout    = v2;
        assign dout[0] = d2[0];
        assign dout[1] = d2[1];
    end else begin : g_lat1
        assign vout    = v1;
        assign dout[0] = d1[0];
        assign dout[1] = d1[1];
    end

    assign s1_readdata      = dout[0];
    assign s2_readdata      = dout[1];
    assign s1_readdatavalid = vout[0] & clken;
    assign s2_readdatavalid = vout[1] & clken;

endmodule

// File: tb/tb_camera_qsys_onchip_ram_dp.sv
// tb/tb_camera_qsys_onchip_ram_dp.sv - scoreboard bench driving a LAT=1/DEPTH=64 and a LAT=2/DEPTH=48 instance
module tb_camera_qsys_onchip_ram_dp;

    localparam int LAT_A = 1;
    localparam int LAT_B = 2;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, clken;
    logic        s1_chipselect, s1_read, s1_write;
    logic [6:0]  s1_address;
    logic [3:0]  s1_byteenable;
    logic [31:0] s1_writedata;
    logic        s2_chipselect, s2_read, s2_write;
    logic [6:0]  s2_address;
    logic [3:0]  s2_byteenable;
    logic [31:0] s2_writedata;

    logic [31:0] a1_rd, a2_rd, b1_rd, b2_rd;
    logic        a1_rv, a2_rv, b1_rv, b2_rv;
    logic        a1_wr, a2_wr, b1_wr, b2_wr;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt     = 0;

    exp_t        q [4][$];
    logic [31:0] ref_a [64];
    logic [31:0] ref_b [48];

    always #5 clk = ~clk;

    always @(posedge clk) if (clken) ecnt <= ecnt + 1;

    camera_qsys_onchip_ram_dp #(
        .DATA_W(32), .DEPTH(64), .ADDR_W(7), .READ_LATENCY(LAT_A), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(a1_rd), .s1_readdatavalid(a1_rv), .s1_waitrequest(a1_wr),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(a2_rd), .s2_readdatavalid(a2_rv), .s2_waitrequest(a2_wr)
    );

    camera_qsys_onchip_ram_dp #(
        .DATA_W(32), .DEPTH(48), .ADDR_W(6), .READ_LATENCY(LAT_B), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address[5:0]), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(b1_rd), .s1_readdatavalid(b1_rv), .s1_waitrequest(b1_wr),
        .s2_address(s2_address[5:0]), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(b2_rd), .s2_readdatavalid(b2_rv), .s2_waitrequest(b2_wr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            check($sformatf("rdv_clken_p%0d", i), 32'(clken), 32'd1);
            if (q[i].size() == 0) begin
                check($sformatf("spurious_rdv_p%0d", i), 32'(q[i].size()), 32'd1);
            end else begin
                e = q[i].pop_front();
                check($sformatf("rdata_p%0d", i), d, e.d);
                check($sformatf("rd_latency_p%0d", i), 32'(ecnt), 32'(e.due));
            end
        end else if (clken && q[i].size() != 0 && q[i][0].due <= ecnt) begin
            e = q[i].pop_front();
            check($sformatf("missing_rdv_p%0d", i), 32'(v), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        mon(0, a1_rv, a1_rd);
        mon(1, a2_rv, a2_rd);
        mon(2, b1_rv, b1_rd);
        mon(3, b2_rv, b2_rd);
    end

    function automatic logic [31:0] rd_a(input logic [6:0] a);
        return (a < 7'd64) ? ref_a[a[5:0]] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_b(input logic [6:0] a);
        logic [5:0] ab;
        ab = a[5:0];
        return (ab < 6'd48) ? ref_b[ab] : 32'h0;
    endfunction

    task automatic wr_model(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [5:0] ab;
        ab = a[5:0];
        for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
                if (a < 7'd64)  ref_a[a[5:0]][l*8 +: 8] = d[l*8 +: 8];
                if (ab < 6'd48) ref_b[ab][l*8 +: 8]     = d[l*8 +: 8];
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) ref_a[i] = 32'h0;
        for (int i = 0; i < 48; i++) ref_b[i] = 32'h0;
    endtask

    task automatic drive_idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
        s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One accepted cycle on both slaves; reads are scored against pre-write contents.
    task automatic xfer(input logic r1, input logic w1, input logic [6:0] a1, input logic [3:0] be1,
                        input logic [31:0] d1, input logic r2, input logic w2, input logic [6:0] a2,
                        input logic [3:0] be2, input logic [31:0] d2);
        check("wreq_ready", 32'({a1_wr, a2_wr, b1_wr, b2_wr}), 32'h0);
        if (r1 && !w1) begin
            q[0].push_back('{d: rd_a(a1), due: ecnt + LAT_A});
            q[2].push_back('{d: rd_b(a1), due: ecnt + LAT_B});
        end
        if (r2 && !w2) begin
            q[1].push_back('{d: rd_a(a2), due: ecnt + LAT_A});
            q[3].push_back('{d: rd_b(a2), due: ecnt + LAT_B});
        end
        if (w2) wr_model(a2, be2, d2);
        if (w1) wr_model(a1, be1, d1);
        s1_chipselect = r1 | w1; s1_read = r1; s1_write = w1;
        s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
        s2_chipselect = r2 | w2; s2_read = r2; s2_write = w2;
        s2_address = a2; s2_byteenable = be2; s2_writedata = d2;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic wait_clear(input string tag);
        int fa, fb;
        fa = -1;
        fb = -1;
        for (int e = 0; e < 200 && (fa < 0 || fb < 0); e++) begin
            @(posedge clk);
            #1;
            if (fa < 0 && !a1_wr) fa = e;
            if (fb < 0 && !b1_wr) fb = e;
        end
        check({tag, "_a"}, 32'(fa), 32'd63);
        check({tag, "_b"}, 32'(fb), 32'd47);
        check({tag, "_s2"}, 32'({a2_wr, b2_wr}), 32'h0);
    endtask

    function automatic logic [6:0] raddr();
        if ($urandom_range(0, 3) == 0) return 7'($urandom_range(40, 70));
        return 7'($urandom_range(0, 11));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        clken   = 1'b1;
        drive_idle();
        clear_model();
        idle(3);
        check("rst_wreq", 32'({a1_wr, a2_wr, b1_wr, b2_wr}), 32'hF);
        check("rst_rdv", 32'({a1_rv, a2_rv, b1_rv, b2_rv}), 32'h0);
        check("rst_rdata", a1_rd | a2_rd | b1_rd | b2_rd, 32'h0);

        reset_n = 1'b1;
        wait_clear("clear_done");

        xfer(1, 0, 7'd0,  4'h0, 32'h0, 1, 0, 7'd0,  4'h0, 32'h0);
        xfer(1, 0, 7'd31, 4'h0, 32'h0, 1, 0, 7'd31, 4'h0, 32'h0);
        xfer(1, 0, 7'd63, 4'h0, 32'h0, 1, 0, 7'd63, 4'h0, 32'h0);

        xfer(0, 1, 7'd5, 4'hF, 32'hA5A5A5A5, 0, 0, 7'd0, 4'h0, 32'h0);
        xfer(0, 1, 7'd5, 4'h5, 32'h11223344, 0, 0, 7'd0, 4'h0, 32'h0);
        xfer(0, 0, 7'd0, 4'h0, 32'h0,        1, 0, 7'd5, 4'h0, 32'h0);

        xfer(1, 1, 7'd6, 4'hF, 32'h12345678, 0, 0, 7'd0, 4'h0, 32'h0);
        xfer(1, 0, 7'd6, 4'h0, 32'h0,        0, 0, 7'd0, 4'h0, 32'h0);

        xfer(0, 1, 7'd9, 4'hC, 32'hFFFF0000, 0, 1, 7'd9, 4'hF, 32'h0000BEEF);
        xfer(1, 0, 7'd9, 4'h0, 32'h0,        1, 0, 7'd9, 4'h0, 32'h0);

        xfer(0, 1, 7'd3, 4'hF, 32'h1, 0, 0, 7'd0, 4'h0, 32'h0);
        xfer(0, 1, 7'd3, 4'hF, 32'h2, 1, 0, 7'd3, 4'h0, 32'h0);
        xfer(0, 0, 7'd0, 4'h0, 32'h0, 1, 0, 7'd3, 4'h0, 32'h0);
        xfer(1, 0, 7'd3, 4'h0, 32'h0, 0, 1, 7'd3, 4'hF, 32'h5);
        xfer(1, 0, 7'd3, 4'h0, 32'h0, 0, 0, 7'd0, 4'h0, 32'h0);

        xfer(0, 1, 7'd50,  4'hF, 32'h0000DEAD, 0, 0, 7'd0, 4'h0, 32'h0);
        xfer(1, 0, 7'd50,  4'h0, 32'h0,        0, 0, 7'd0, 4'h0, 32'h0);
        xfer(0, 1, 7'd100, 4'hF, 32'h0000BEEF, 0, 1, 7'd40, 4'hF, 32'hCAFE0040);
        xfer(1, 0, 7'd100, 4'h0, 32'h0,        1, 0, 7'd40, 4'h0, 32'h0);

        s1_chipselect = 1'b0; s1_read = 1'b1; s1_address = 7'd5;
        idle(1);
        drive_idle();
        idle(3);

        xfer(1, 0, 7'd3, 4'h0, 32'h0, 1, 0, 7'd3, 4'h0, 32'h0);
        clken = 1'b0;
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 7'd3;
        s1_byteenable = 4'hF; s1_writedata = 32'h77;
        idle(1);
        check("freeze_wreq", 32'({a1_wr, b1_wr}), 32'h3);
        idle(2);
        clken = 1'b1;
        drive_idle();
        idle(4);
        xfer(0, 0, 7'd0, 4'h0, 32'h0, 1, 0, 7'd3, 4'h0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr(), 4'($urandom_range(0, 15)),
                 $urandom(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr(), 4'($urandom_range(0, 15)),
                 $urandom());
        end
        idle(4);
        check("drained", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'h0);

        reset_n = 1'b0;
        idle(2);
        clear_model();
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midclr_wreq", 32'({a1_wr, a2_wr, b1_wr, b2_wr}), 32'hF);
        idle(2);
        reset_n = 1'b1;
        wait_clear("clear_restart");

        xfer(1, 0, 7'd5, 4'h0, 32'h0, 1, 0, 7'd40, 4'h0, 32'h0);
        xfer(1, 0, 7'd9, 4'h0, 32'h0, 1, 0, 7'd63, 4'h0, 32'h0);
        idle(4);
        check("drained_end", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
